// File: rtl/pwr_sweep_pkg.sv
// pwr_sweep_pkg: shared types, mode codes and thermometer helper for the sweep sequencer
package pwr_sweep_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_DONE} state_t;
  localparam logic [1:0] MODE_PWR = 2'd0;
  localparam logic [1:0] MODE_PWR_OPT = 2'd1;
  localparam logic [1:0] MODE_OPT_ONLY = 2'd2;
  // wide enough for any N_DUT the sequencer is built with; callers truncate
  localparam int THERMO_W = 64;
  function automatic logic [THERMO_W-1:0] thermo(input int unsigned k);
    return (THERMO_W'(1) << k) - THERMO_W'(1);
  endfunction
endpackage

// File: rtl/pwr_sweep_seq_dwell_timer.sv
// dwell_timer: loadable down-counter that holds at zero and flags it
// ports: clk100m/rst clock and async reset; load/load_val reload; zero high when count is 0
module dwell_timer #(
  parameter int DWELL_W = 32
) (
  input  logic               clk100m,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);
  logic [DWELL_W-1:0] cnt;
  always_ff @(posedge clk100m or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - DWELL_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/pwr_sweep_seq.sv
// pwr_sweep_seq: thermometer sweep of per-DUT power/opt enables with programmable dwell
// ports: clk100m/rst clock and async reset; start/abort/mode/dwell_cycles control;
//        pwr_en_out/opt_en_out enable masks; phase_idx/phase_strobe phase marks; busy/done/aborted status
module pwr_sweep_seq
  import pwr_sweep_pkg::*;
#(
  parameter int N_DUT = 32,
  parameter int DWELL_W = 32,
  parameter int PH_W = 6
) (
  input  logic               clk100m,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [N_DUT-1:0]   pwr_en_out,
  output logic [N_DUT-1:0]   opt_en_out,
  output logic [PH_W-1:0]    phase_idx,
  output logic               phase_strobe,
  output logic               busy,
  output logic               done,
  output logic               aborted
);
  state_t state, state_n;
  logic [PH_W-1:0] phase, phase_n;
  logic [1:0] mode_q, mode_n;
  logic [DWELL_W-1:0] d_q, d_n;
  logic zero, go, adv, fin;
  logic [THERMO_W-1:0] th;
  logic [N_DUT-1:0] pwr_d, opt_d;
  logic [PH_W-1:0] idx_d;
  logic strobe_d, busy_d, done_d, aborted_d;
  assign go = state == ST_IDLE && start && !abort;
  assign adv = state == ST_DWELL && !abort && zero && phase != PH_W'(N_DUT);
  assign fin = state == ST_DWELL && !abort && zero && phase == PH_W'(N_DUT);
  assign phase_n = go ? '0 : adv ? phase + PH_W'(1) : phase;
  assign mode_n = go ? mode : mode_q;
  assign d_n = go ? (dwell_cycles == '0 ? DWELL_W'(1) : dwell_cycles) : d_q;
  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk100m (clk100m),
    .rst     (rst),
    .load    (go | adv),
    .load_val(d_n - DWELL_W'(1)),
    .zero    (zero)
  );
  always_ff @(posedge clk100m or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      phase <= '0;
      mode_q <= MODE_PWR;
      d_q <= DWELL_W'(1);
    end else begin
      state <= state_n;
      phase <= phase_n;
      mode_q <= mode_n;
      d_q <= d_n;
    end
  always_comb
    state_n = state == ST_IDLE ? (go ? ST_DWELL : ST_IDLE) :
              state == ST_DWELL ? (abort ? ST_IDLE : fin ? ST_DONE : ST_DWELL) : ST_IDLE;
  // outputs are computed from the next state so the registered copies line up with it
  always_comb begin
    th = thermo(32'(phase_n));
    pwr_d = state_n != ST_DWELL ? '0 : mode_n == MODE_OPT_ONLY ? '1 : N_DUT'(th);
    opt_d = state_n == ST_DWELL && (mode_n == MODE_PWR_OPT || mode_n == MODE_OPT_ONLY) ? N_DUT'(th) : '0;
    idx_d = state_n == ST_DWELL ? phase_n : '0;
    strobe_d = go | adv;
    busy_d = state_n != ST_IDLE;
    done_d = state_n == ST_DONE;
    aborted_d = state == ST_DWELL && abort;
  end
  always_ff @(posedge clk100m or posedge rst)
    if (rst) begin
      pwr_en_out <= '0;
      opt_en_out <= '0;
      phase_idx <= '0;
      phase_strobe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      pwr_en_out <= pwr_d;
      opt_en_out <= opt_d;
      phase_idx <= idx_d;
      phase_strobe <= strobe_d;
      busy <= busy_d;
      done <= done_d;
      aborted <= aborted_d;
    end
endmodule

// File: tb/tb_pwr_sweep_seq.sv
// tb_pwr_sweep_seq: directed self-checking bench for the sweep sequencer with four DUT slots
module tb_pwr_sweep_seq;
  localparam int N = 4;
  logic clk100m = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [31:0] dwell_cycles = 32'd0;
  logic [N-1:0] pwr_en_out, opt_en_out;
  logic [5:0] phase_idx;
  logic phase_strobe, busy, done, aborted;
  int n_vec = 0;
  int n_err = 0;
  pwr_sweep_seq #(.N_DUT(N), .DWELL_W(32), .PH_W(6)) dut (
    .clk100m     (clk100m),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .dwell_cycles(dwell_cycles),
    .pwr_en_out  (pwr_en_out),
    .opt_en_out  (opt_en_out),
    .phase_idx   (phase_idx),
    .phase_strobe(phase_strobe),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );
  always #5 clk100m = ~clk100m;
  task automatic tick;
    @(posedge clk100m);
    @(negedge clk100m);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic chk_idle(input string tag, input logic exp_abort);
    chk({tag, " pwr"}, 64'(pwr_en_out), 0);
    chk({tag, " opt"}, 64'(opt_en_out), 0);
    chk({tag, " idx"}, 64'(phase_idx), 0);
    chk({tag, " strobe"}, 64'(phase_strobe), 0);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " done"}, 64'(done), 0);
    chk({tag, " aborted"}, 64'(aborted), 64'(exp_abort));
  endtask
  // full sweep from IDLE; perturb re-pulses start and changes mode/dwell mid-sweep, then aborts in DONE
  task automatic sweep(input int dw, input logic [1:0] md, input bit perturb);
    int d, k, strobes, busy_cnt;
    logic [N-1:0] th, ep, eo;
    d = dw == 0 ? 1 : dw;
    strobes = 0;
    busy_cnt = 0;
    dwell_cycles = 32'(dw);
    mode = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= (N + 1) * d; c++) begin
      k = (c - 1) / d;
      th = N'((1 << k) - 1);
      ep = md == 2'd2 ? '1 : th;
      eo = (md == 2'd1 || md == 2'd2) ? th : '0;
      chk("sweep pwr", 64'(pwr_en_out), 64'(ep));
      chk("sweep opt", 64'(opt_en_out), 64'(eo));
      chk("sweep idx", 64'(phase_idx), 64'(k));
      chk("sweep strobe", 64'(phase_strobe), 64'((c - 1) % d == 0));
      chk("sweep busy", 64'(busy), 1);
      chk("sweep done", 64'(done), 0);
      strobes += int'(phase_strobe);
      busy_cnt += int'(busy);
      if (perturb && c == 4) begin
        start = 1'b1;
        mode = md ^ 2'd1;
        dwell_cycles = 32'd9;
      end
      if (c == 5) start = 1'b0;
      tick();
    end
    chk("done pulse", 64'(done), 1);
    chk("done busy", 64'(busy), 1);
    chk("done pwr", 64'(pwr_en_out), 0);
    chk("done opt", 64'(opt_en_out), 0);
    busy_cnt += int'(busy);
    chk("strobe count", 64'(strobes), 64'(N + 1));
    chk("busy count", 64'((N + 1) * d + 1), 64'(busy_cnt));
    if (perturb) abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("after done", 1'b0);
  endtask
  initial begin
    #2;
    chk_idle("reset", 1'b0);
    @(negedge clk100m);
    rst = 1'b0;
    tick();
    chk_idle("idle", 1'b0);
    sweep(3, 2'd0, 1'b0);
    sweep(1, 2'd2, 1'b0);
    sweep(0, 2'd1, 1'b0);
    sweep(2, 2'd3, 1'b0);
    sweep(3, 2'd0, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start+abort", 1'b0);
    tick();
    chk_idle("start+abort later", 1'b0);
    dwell_cycles = 32'd5;
    mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    chk("abort pre idx", 64'(phase_idx), 2);
    chk("abort pre pwr", 64'(pwr_en_out), 64'h3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort", 1'b1);
    tick();
    chk_idle("abort after", 1'b0);
    sweep(1, 2'd0, 1'b0);
    dwell_cycles = 32'd2;
    mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    chk("rst pre idx", 64'(phase_idx), 3);
    chk("rst pre opt", 64'(opt_en_out), 64'h7);
    #2 rst = 1'b1;
    #1;
    chk_idle("async rst", 1'b0);
    @(negedge clk100m);
    rst = 1'b0;
    chk_idle("rst held", 1'b0);
    tick();
    chk_idle("rst released", 1'b0);
    sweep(1, 2'd1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
